// File: rtl/hex_uart_pkg.sv
// Shared definitions for the hex UART transmitter: FSM encoding and frame geometry.
package hex_uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  localparam logic [5:0] IDLE_WORD  = 6'h3F;
  localparam int         FRAME_BITS = 9;
  localparam int         DATA_BITS  = 6;

endpackage

// File: rtl/hex_uart_baud.sv
// Bit-period timer: tick is high in the last cycle of each CLK_DIV-cycle bit period.
module hex_uart_baud #(
  parameter int CLK_DIV = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);

  logic [7:0] cnt;

  assign tick = (cnt == 8'(CLK_DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (restart || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 8'd1;
    end
  end

endmodule

// File: rtl/hex_uart_tx.sv
// Serialises 6-bit words from the upstream hex shift register as start/6 data/even parity/stop frames.
// Handshake: ack pulses for one cycle after the edge that latches data_in; the upstream may then advance.
module hex_uart_tx
  import hex_uart_pkg::*;
#(
  parameter int CLK_DIV = 16
) (
  input  logic [7:0] io_in,
  output logic [7:0] io_out
);

  logic       clk;
  logic       rst;
  logic [5:0] data_in;

  assign clk     = io_in[0];
  assign rst     = io_in[1];
  assign data_in = io_in[7:2];

  state_t     state, state_next;
  logic       tx, tx_next;
  logic       busy, busy_next;
  logic       ack, ack_next;
  logic [4:0] frame_cnt;
  logic [2:0] bit_idx, idx_next, idx_inc;
  logic [5:0] data_q, data_shift;
  logic       latch, done, restart, tick;

  assign io_out = {frame_cnt, ack, busy, tx};

  // Counter is held at zero in IDLE so the first bit period starts at the latching edge.
  hex_uart_baud #(.CLK_DIV(CLK_DIV)) u_baud (
    .clk     (clk),
    .rst     (rst),
    .restart (restart),
    .tick    (tick)
  );

  assign idx_inc    = bit_idx + 3'd1;
  assign data_shift = data_q >> idx_inc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    tx_next    = tx;
    busy_next  = busy;
    ack_next   = 1'b0;
    idx_next   = bit_idx;
    latch      = 1'b0;
    done       = 1'b0;
    restart    = 1'b0;
    unique case (state)
      IDLE: begin
        restart   = 1'b1;
        tx_next   = 1'b1;
        busy_next = 1'b0;
        if (data_in != IDLE_WORD) begin
          latch      = 1'b1;
          state_next = START;
          tx_next    = 1'b0;
          busy_next  = 1'b1;
          ack_next   = 1'b1;
          idx_next   = 3'd0;
        end
      end
      START: begin
        if (tick) begin
          state_next = DATA;
          tx_next    = data_q[0];
          idx_next   = 3'd0;
        end
      end
      DATA: begin
        if (tick) begin
          if (bit_idx == 3'(DATA_BITS - 1)) begin
            state_next = PARITY;
            tx_next    = ^data_q;
          end else begin
            idx_next = idx_inc;
            tx_next  = data_shift[0];
          end
        end
      end
      PARITY: begin
        if (tick) begin
          state_next = STOP;
          tx_next    = 1'b1;
        end
      end
      STOP: begin
        if (tick) begin
          state_next = IDLE;
          tx_next    = 1'b1;
          busy_next  = 1'b0;
          done       = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        tx_next    = 1'b1;
        busy_next  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx        <= 1'b1;
      busy      <= 1'b0;
      ack       <= 1'b0;
      frame_cnt <= '0;
      bit_idx   <= '0;
      data_q    <= '0;
    end else begin
      tx      <= tx_next;
      busy    <= busy_next;
      ack     <= ack_next;
      bit_idx <= idx_next;
      if (latch) begin
        data_q <= data_in;
      end
      if (done) begin
        frame_cnt <= frame_cnt + 5'd1;
      end
    end
  end

endmodule
